// File: rtl/twiddle_factor_gen.sv
// Radix-2 DIT FFT twiddle source: streams the twiddles for one stage in butterfly order,
// derived from a quarter-wave cosine ROM, over a valid/ready interface with full backpressure.
module twiddle_factor_gen #(
  parameter int N_POINTS = 32,
  parameter int DATA_W   = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [3:0]                  stage,
  input  logic                        inverse,
  output logic                        busy,
  output logic                        cfg_err,
  output logic                        tw_valid,
  input  logic                        tw_ready,
  output logic signed [DATA_W-1:0]    tw_real,
  output logic signed [DATA_W-1:0]    tw_imag,
  output logic [$clog2(N_POINTS)-1:0] tw_k,
  output logic                        tw_last
);

  localparam int  LOG2N = $clog2(N_POINTS);
  localparam int  Q     = N_POINTS / 4;
  localparam int  AW    = LOG2N - 1;
  localparam real PI    = 3.14159265358979323846;
  localparam real FS    = $itor((1 << (DATA_W - 1)) - 1);

  logic signed [DATA_W-1:0] cos_tab [Q+1];

  for (genvar gi = 0; gi <= Q; gi++) begin : g_tab
    localparam real ANG = 2.0 * PI * $itor(gi) / $itor(N_POINTS);
    localparam int  VAL = $rtoi($floor($cos(ANG) * FS + 0.5));
    assign cos_tab[gi] = DATA_W'(VAL);
  end

  typedef enum logic [1:0] {G_IDLE, G_ISSUE, G_DRAIN} gen_state_e;

  gen_state_e       state_q, state_d;
  logic [LOG2N-1:0] j_q, j_d;
  logic [3:0]       s_q, s_d;
  logic             inv_q, inv_d;
  logic             cfg_err_d;

  logic             adv, issue, j_last, stage_ok, hi_sel;
  logic [LOG2N-1:0] k_issue;
  logic [AW-1:0]    a_addr, b_addr;

  logic                     v1_q, last1_q, hi1_q;
  logic [LOG2N-1:0]         k1_q;
  logic signed [DATA_W-1:0] ra1_q, rb1_q;

  logic                     v2_q, last2_q;
  logic [LOG2N-1:0]         k2_q;
  logic signed [DATA_W-1:0] re2_q, im2_q;

  assign adv      = !tw_valid || tw_ready;
  assign issue    = (state_q == G_ISSUE) && adv;
  assign stage_ok = int'(stage) < LOG2N;
  assign j_last   = j_q == LOG2N'((32'd1 << s_q) - 32'd1);
  assign busy     = state_q != G_IDLE;

  // k = j * N / 2^(s+1) is a left shift of j by (LOG2N-1-s)
  assign k_issue = j_q << (4'(LOG2N - 1) - s_q);
  assign hi_sel  = k_issue > LOG2N'(Q);
  assign a_addr  = AW'(hi_sel ? LOG2N'(2 * Q) - k_issue : k_issue);
  assign b_addr  = AW'(hi_sel ? k_issue - LOG2N'(Q) : LOG2N'(Q) - k_issue);

  always_comb begin
    state_d   = state_q;
    j_d       = j_q;
    s_d       = s_q;
    inv_d     = inv_q;
    cfg_err_d = 1'b0;
    unique case (state_q)
      G_IDLE: begin
        if (start) begin
          if (stage_ok) begin
            state_d = G_ISSUE;
            j_d     = '0;
            s_d     = stage;
            inv_d   = inverse;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      G_ISSUE: begin
        if (adv) begin
          if (j_last) state_d = G_DRAIN;
          else        j_d     = j_q + LOG2N'(1);
        end
      end
      G_DRAIN: begin
        if (tw_valid && tw_ready && tw_last) state_d = G_IDLE;
      end
      default: state_d = G_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= G_IDLE;
      j_q      <= '0;
      s_q      <= '0;
      inv_q    <= 1'b0;
      cfg_err  <= 1'b0;
      v1_q     <= 1'b0;
      last1_q  <= 1'b0;
      hi1_q    <= 1'b0;
      k1_q     <= '0;
      ra1_q    <= '0;
      rb1_q    <= '0;
      v2_q     <= 1'b0;
      last2_q  <= 1'b0;
      k2_q     <= '0;
      re2_q    <= '0;
      im2_q    <= '0;
      tw_valid <= 1'b0;
      tw_last  <= 1'b0;
      tw_real  <= '0;
      tw_imag  <= '0;
      tw_k     <= '0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      s_q     <= s_d;
      inv_q   <= inv_d;
      cfg_err <= cfg_err_d;
      if (adv) begin
        v1_q <= issue;
        if (issue) begin
          k1_q    <= k_issue;
          last1_q <= j_last;
          hi1_q   <= hi_sel;
          ra1_q   <= cos_tab[a_addr];
          rb1_q   <= cos_tab[b_addr];
        end
        v2_q <= v1_q;
        if (v1_q) begin
          k2_q    <= k1_q;
          last2_q <= last1_q;
          re2_q   <= hi1_q ? -ra1_q : ra1_q;
          im2_q   <= inv_q ? rb1_q : -rb1_q;
        end
        tw_valid <= v2_q;
        tw_last  <= v2_q && last2_q;
        if (v2_q) begin
          tw_real <= re2_q;
          tw_imag <= im2_q;
          tw_k    <= k2_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_twiddle_factor_gen.sv
// Randomised bench for twiddle_factor_gen: outputs compared against twiddles computed
// directly from e^{-j2πk/N} with real arithmetic.
module tb_twiddle_factor_gen;

  localparam int  N  = 32;
  localparam int  DW = 16;
  localparam int  LG = 5;
  localparam real PI = 3.14159265358979323846;
  localparam real FS = 32767.0;

  logic                 clk = 1'b0;
  logic                 rst, start, inverse, tw_ready;
  logic [3:0]           stage;
  logic                 busy, cfg_err, tw_valid, tw_last;
  logic signed [DW-1:0] tw_real, tw_imag;
  logic [LG-1:0]        tw_k;

  int checks = 0;
  int errors = 0;

  int exp_re[$], exp_im[$], exp_k[$];
  int got_re[$], got_im[$];

  always #5 clk = ~clk;

  twiddle_factor_gen #(.N_POINTS(N), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .stage(stage), .inverse(inverse),
    .busy(busy), .cfg_err(cfg_err), .tw_valid(tw_valid), .tw_ready(tw_ready),
    .tw_real(tw_real), .tw_imag(tw_imag), .tw_k(tw_k), .tw_last(tw_last)
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int rnd(input real r);
    if (r >= 0.0) return $rtoi($floor(r + 0.5));
    else          return -$rtoi($floor(-r + 0.5));
  endfunction

  task automatic build_expected(input int s, input bit inv);
    exp_re.delete(); exp_im.delete(); exp_k.delete();
    for (int j = 0; j < (1 << s); j++) begin
      int  k;
      real th;
      int  im;
      k  = j * N / (1 << (s + 1));
      th = 2.0 * PI * $itor(k) / $itor(N);
      im = -rnd($sin(th) * FS);
      exp_k.push_back(k);
      exp_re.push_back(rnd($cos(th) * FS));
      exp_im.push_back(inv ? -im : im);
    end
  endtask

  task automatic run_stage(input int s, input bit inv, input bit rand_ready,
                           input bit poke, input int abort_at);
    int n, cyc, first, n_got, cfg_seen;
    bit stall;
    logic signed [DW-1:0] h_re, h_im;
    logic [LG-1:0] h_k;
    logic h_last;
    build_expected(s, inv);
    got_re.delete(); got_im.delete();
    n = 1 << s;
    @(negedge clk); start = 1'b1; stage = 4'(s); inverse = inv;
    @(negedge clk); start = 1'b0;
    cyc = 0; n_got = 0; first = -1; stall = 1'b0; cfg_seen = 0;
    h_re = '0; h_im = '0; h_k = '0; h_last = 1'b0;
    while (n_got < n && n_got != abort_at && cyc < 400) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (cfg_err) cfg_seen++;
      if (stall) begin
        chk("stall_re", tw_real, h_re);
        chk("stall_im", tw_imag, h_im);
        chk("stall_k", tw_k, h_k);
        chk("stall_last", tw_last, h_last);
      end
      if (tw_valid && first < 0) first = cyc;
      if (poke && cyc == 2) begin start = 1'b1; stage = 4'd1; end
      tw_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      stall = 1'b0;
      if (tw_valid && tw_ready) begin
        chk("re", tw_real, exp_re[n_got]);
        chk("im", tw_imag, exp_im[n_got]);
        chk("k", tw_k, exp_k[n_got]);
        chk("last", tw_last, (n_got == n - 1) ? 1 : 0);
        got_re.push_back(int'(tw_real));
        got_im.push_back(int'(tw_imag));
        n_got++;
        if (n_got == n) chk("busy_at_last", busy, 1);
      end else if (tw_valid) begin
        stall = 1'b1;
        h_re = tw_real; h_im = tw_imag; h_k = tw_k; h_last = tw_last;
      end
    end
    if (abort_at < 0) begin
      chk("out_count", n_got, n);
      chk("first_valid_lat", first, 3);
      @(negedge clk);
      if (cfg_err) cfg_seen++;
      chk("busy_after_last", busy, 0);
      chk("valid_after_last", tw_valid, 0);
      chk("no_cfg_err", cfg_seen, 0);
    end else begin
      chk("abort_count", n_got, abort_at);
    end
  endtask

  initial begin
    int seen;
    rst = 1'b1; start = 1'b0; stage = '0; inverse = 1'b0; tw_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_valid", tw_valid, 0);
    chk("rst_last", tw_last, 0);
    chk("rst_re", tw_real, 0);
    chk("rst_im", tw_imag, 0);
    chk("rst_k", tw_k, 0);
    rst = 1'b0;

    run_stage(0, 1'b0, 1'b0, 1'b0, -1);
    chk("s0_re", got_re[0], 32767);
    chk("s0_im", got_im[0], 0);

    run_stage(2, 1'b0, 1'b0, 1'b0, -1);
    chk("s2_re1", got_re[1], 23170);
    chk("s2_im1", got_im[1], -23170);
    chk("s2_re2", got_re[2], 0);
    chk("s2_im2", got_im[2], -32767);
    chk("s2_re3", got_re[3], -23170);
    chk("s2_im3", got_im[3], -23170);

    // inverse run with a start pulse issued mid-stream, which must be ignored
    run_stage(4, 1'b1, 1'b0, 1'b1, -1);
    chk("inv_k8_re", got_re[8], 0);
    chk("inv_k8_im", got_im[8], 32767);
    chk("inv_k12_re", got_re[12], -23170);
    chk("inv_k12_im", got_im[12], 23170);

    run_stage(4, 1'b0, 1'b1, 1'b0, -1);

    @(negedge clk); start = 1'b1; stage = 4'd5; inverse = 1'b0;
    @(negedge clk); start = 1'b0;
    chk("cfg_err_pulse", cfg_err, 1);
    chk("cfg_busy", busy, 0);
    @(negedge clk);
    chk("cfg_err_clear", cfg_err, 0);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (tw_valid || busy || cfg_err) seen++;
    end
    chk("cfg_no_output", seen, 0);

    tw_ready = 1'b1;
    run_stage(4, 1'b0, 1'b0, 1'b0, 6);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", tw_valid, 0);
    chk("mid_rst_last", tw_last, 0);
    chk("mid_rst_re", tw_real, 0);
    chk("mid_rst_im", tw_imag, 0);
    chk("mid_rst_k", tw_k, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_rst_valid", tw_valid, 0);
    run_stage(3, 1'b0, 1'b0, 1'b0, -1);

    for (int r = 0; r < 5; r++) begin
      run_stage(int'($urandom_range(0, LG - 1)), 1'($urandom_range(0, 1)), 1'b1, 1'b0, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
